// File: rtl/wb_regfile_writer.sv
// Write-back stage: commits MEM-latch results to the register file and flag register.
// Optional SHADOW_BANK_EN adds a second copy of ids 1..6 and of the flags, selected by bank bits.
module wb_regfile_writer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ID_W   = 5,
  parameter int unsigned FLAG_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ID_W-1:0]   Wr_id_in,
  input  logic [FLAG_W-1:0] Fmask_in,
  input  logic [DATA_W-1:0] Result_in,
  input  logic [FLAG_W-1:0] Flags_in,
  input  logic [ID_W-1:0]   rd_a_id,
  input  logic [ID_W-1:0]   rd_b_id,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic [FLAG_W-1:0] flags_out,
  output logic [15:0]       wr_count,
  input  logic              exx,
  input  logic              ex_af
);

  localparam int unsigned NumRegs = 2 ** ID_W;

  logic [NumRegs-1:0][DATA_W-1:0] regs_q;
  logic [FLAG_W-1:0]              f_q;
  logic [FLAG_W-1:0]              f_cur;
  logic [FLAG_W-1:0]              f_d;
  logic [15:0]                    wr_count_q;
  logic                           wr_en;

  assign wr_en = (Wr_id_in != '0);

`ifdef SHADOW_BANK_EN
  // Entries 0 and 7 exist only so a 3-bit id slice can index directly; they stay at 0.
  logic [7:0][DATA_W-1:0] shadow_q;
  logic [FLAG_W-1:0]      f_shadow_q;
  logic                   rb_q;
  logic                   fb_q;
  logic                   wr_banked;

  function automatic logic is_banked(input logic [ID_W-1:0] id);
    return (id != '0) && (id <= ID_W'(6));
  endfunction

  assign wr_banked = rb_q && is_banked(Wr_id_in);
  assign f_cur     = fb_q ? f_shadow_q : f_q;
`else
  logic unused_swap;
  assign unused_swap = exx ^ ex_af;
  assign f_cur       = f_q;
`endif

  assign f_d       = (f_cur & ~Fmask_in) | (Flags_in & Fmask_in);
  assign flags_out = f_d;
  assign wr_count  = wr_count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      regs_q     <= '0;
      f_q        <= '0;
      wr_count_q <= '0;
`ifdef SHADOW_BANK_EN
      shadow_q   <= '0;
      f_shadow_q <= '0;
      rb_q       <= 1'b0;
      fb_q       <= 1'b0;
`endif
    end else begin
      if (wr_en) begin
        wr_count_q <= wr_count_q + 16'd1;
`ifdef SHADOW_BANK_EN
        if (wr_banked) begin
          shadow_q[Wr_id_in[2:0]] <= Result_in;
        end else begin
          regs_q[Wr_id_in] <= Result_in;
        end
`else
        regs_q[Wr_id_in] <= Result_in;
`endif
      end
`ifdef SHADOW_BANK_EN
      // Writes above use the pre-toggle bank; the swap takes effect from the next cycle.
      if (fb_q) begin
        f_shadow_q <= f_d;
      end else begin
        f_q <= f_d;
      end
      rb_q <= rb_q ^ exx;
      fb_q <= fb_q ^ ex_af;
`else
      f_q <= f_d;
`endif
    end
  end

  always_comb begin
    rd_a_data = '0;
    if (rd_a_id == '0) begin
      rd_a_data = '0;
    end else if (rd_a_id == Wr_id_in) begin
      rd_a_data = Result_in;
`ifdef SHADOW_BANK_EN
    end else if (rb_q && is_banked(rd_a_id)) begin
      rd_a_data = shadow_q[rd_a_id[2:0]];
`endif
    end else begin
      rd_a_data = regs_q[rd_a_id];
    end
  end

  always_comb begin
    rd_b_data = '0;
    if (rd_b_id == '0) begin
      rd_b_data = '0;
    end else if (rd_b_id == Wr_id_in) begin
      rd_b_data = Result_in;
`ifdef SHADOW_BANK_EN
    end else if (rb_q && is_banked(rd_b_id)) begin
      rd_b_data = shadow_q[rd_b_id[2:0]];
`endif
    end else begin
      rd_b_data = regs_q[rd_b_id];
    end
  end

endmodule

// File: tb/tb_wb_regfile_writer.sv
// Scoreboard bench for wb_regfile_writer; covers the SHADOW_BANK_EN build when the macro is set.
module tb_wb_regfile_writer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ID_W   = 5;
  localparam int unsigned FLAG_W = 8;

  logic              CLK = 1'b0;
  logic              RST;
  logic [ID_W-1:0]   Wr_id_in;
  logic [FLAG_W-1:0] Fmask_in;
  logic [DATA_W-1:0] Result_in;
  logic [FLAG_W-1:0] Flags_in;
  logic [ID_W-1:0]   rd_a_id;
  logic [ID_W-1:0]   rd_b_id;
  logic [DATA_W-1:0] rd_a_data;
  logic [DATA_W-1:0] rd_b_data;
  logic [FLAG_W-1:0] flags_out;
  logic [15:0]       wr_count;
  logic              exx;
  logic              ex_af;

  always #5 CLK = ~CLK;

  wb_regfile_writer #(
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .FLAG_W (FLAG_W)
  ) u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .Wr_id_in  (Wr_id_in),
    .Fmask_in  (Fmask_in),
    .Result_in (Result_in),
    .Flags_in  (Flags_in),
    .rd_a_id   (rd_a_id),
    .rd_b_id   (rd_b_id),
    .rd_a_data (rd_a_data),
    .rd_b_data (rd_b_data),
    .flags_out (flags_out),
    .wr_count  (wr_count),
    .exx       (exx),
    .ex_af     (ex_af)
  );

  typedef struct {
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  logic [15:0] m_regs [32];
  logic [15:0] m_sh   [8];
  logic [7:0]  m_f;
  logic [7:0]  m_fsh;
  logic [15:0] m_cnt;
  logic        m_rb;
  logic        m_fb;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%04h, expected 0x%04h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [4:0] id, input logic [4:0] wr,
                                          input logic [15:0] res);
    if (id == 5'd0) return 16'h0000;
    if (id == wr) return res;
    if (m_rb && id >= 5'd1 && id <= 5'd6) return m_sh[id[2:0]];
    return m_regs[id];
  endfunction

  function automatic logic [7:0] m_fnext(input logic [7:0] fm, input logic [7:0] fl);
    logic [7:0] cur;
    cur = m_fb ? m_fsh : m_f;
    return (cur & ~fm) | (fl & fm);
  endfunction

  task automatic step(input logic rst, input logic [4:0] wr, input logic [15:0] res,
                      input logic [7:0] fm, input logic [7:0] fl, input logic [4:0] ra,
                      input logic [4:0] rb, input logic x, input logic xa, input bit chk,
                      input string name);
    exp_t       e;
    logic [15:0] obs;
    string      what;
    logic [7:0] nf;
    @(negedge CLK);
    RST = rst; Wr_id_in = wr; Result_in = res; Fmask_in = fm; Flags_in = fl;
    rd_a_id = ra; rd_b_id = rb; exx = x; ex_af = xa;
    nf = m_fnext(fm, fl);
    if (chk) begin
      sb_q.push_back('{sel: 0, val: m_read(ra, wr, res)});
      sb_q.push_back('{sel: 1, val: m_read(rb, wr, res)});
      sb_q.push_back('{sel: 2, val: {8'h00, nf}});
      sb_q.push_back('{sel: 3, val: m_cnt});
    end
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        0:       begin obs = rd_a_data;          what = "rd_a";     end
        1:       begin obs = rd_b_data;          what = "rd_b";     end
        2:       begin obs = {8'h00, flags_out}; what = "flags";    end
        default: begin obs = wr_count;           what = "wr_count"; end
      endcase
      check_eq($sformatf("%s.%s", name, what), obs, e.val);
    end
    @(posedge CLK);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
      for (int i = 0; i < 8; i++) m_sh[i] = 16'h0000;
      m_f = 8'h00; m_fsh = 8'h00; m_cnt = 16'h0000; m_rb = 1'b0; m_fb = 1'b0;
    end else begin
      if (wr != 5'd0) begin
        if (m_rb && wr <= 5'd6) m_sh[wr[2:0]] = res;
        else m_regs[wr] = res;
        m_cnt = m_cnt + 16'd1;
      end
      if (m_fb) m_fsh = nf;
      else m_f = nf;
`ifdef SHADOW_BANK_EN
      m_rb = m_rb ^ x;
      m_fb = m_fb ^ xa;
`endif
    end
  endtask

  initial begin
    m_rb = 1'b0; m_fb = 1'b0; m_f = 8'h00; m_fsh = 8'h00; m_cnt = 16'h0000;
    // Reset for two cycles with a pending write; state is unknown during the first one
    step(1, 5'd5, 16'hBEEF, 8'hFF, 8'hFF, 5'd5, 5'd0, 0, 0, 0, "rst0");
    step(1, 5'd5, 16'hBEEF, 8'hFF, 8'hFF, 5'd5, 5'd0, 0, 0, 1, "rst1");
    step(0, 5'd0, 16'h0000, 8'h00, 8'h00, 5'd5, 5'd5, 0, 0, 1, "post_rst");

    // Write with same-cycle bypass, then registered read
    step(0, 5'd3, 16'h1234, 8'h00, 8'h00, 5'd3, 5'd3, 0, 0, 1, "byp");
    step(0, 5'd0, 16'h0000, 8'h00, 8'h00, 5'd3, 5'd0, 0, 0, 1, "rd3");

    // Null destination
    for (int i = 0; i < 4; i++)
      step(0, 5'd0, 16'hFFFF, 8'h00, 8'h00, 5'd3, 5'd0, 0, 0, 1, $sformatf("null%0d", i));

    // Flag masking
    step(0, 5'd0, 16'h0000, 8'h81, 8'hFF, 5'd0, 5'd0, 0, 0, 1, "fl_81");
    step(0, 5'd0, 16'h0000, 8'h01, 8'h00, 5'd0, 5'd0, 0, 0, 1, "fl_01");
    step(0, 5'd0, 16'h0000, 8'h00, 8'h55, 5'd0, 5'd0, 0, 0, 1, "fl_00a");
    step(0, 5'd0, 16'h0000, 8'h00, 8'hAA, 5'd0, 5'd0, 0, 0, 1, "fl_00b");

    // Stall-held write
    for (int i = 0; i < 3; i++)
      step(0, 5'd7, 16'h00AA, 8'h00, 8'h00, 5'd3, 5'd7, 0, 0, 1, $sformatf("hold%0d", i));
    step(0, 5'd0, 16'h0000, 8'h00, 8'h00, 5'd7, 5'd7, 0, 0, 1, "rd7");

    // Reset wins over a simultaneous write and flag update
    step(1, 5'd4, 16'h5555, 8'hFF, 8'hFF, 5'd7, 5'd4, 1, 1, 1, "rst_mid");
    step(0, 5'd0, 16'h0000, 8'h00, 8'h00, 5'd4, 5'd7, 0, 0, 1, "after_rst");

    // Random traffic; exx/ex_af are ignored unless the shadow bank is built in
    for (int i = 0; i < 60; i++)
      step(0, 5'($urandom_range(0, 31)), 16'($urandom), 8'($urandom), 8'($urandom),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom),
           1'($urandom), 1, $sformatf("rnd%0d", i));

    // Count up to 0xFFFF, then wrap
    while (m_cnt != 16'hFFFF)
      step(0, 5'd9, m_cnt, 8'h00, 8'h00, 5'd0, 5'd0, 0, 0, 0, "bulk");
    step(0, 5'd0, 16'h0000, 8'h00, 8'h00, 5'd9, 5'd0, 0, 0, 1, "cnt_ffff");
    step(0, 5'd9, 16'hCAFE, 8'h00, 8'h00, 5'd9, 5'd0, 0, 0, 1, "cnt_last");
    step(0, 5'd0, 16'h0000, 8'h00, 8'h00, 5'd9, 5'd0, 0, 0, 1, "cnt_wrap");

`ifdef SHADOW_BANK_EN
    step(1, 5'd0, 16'h0000, 8'h00, 8'h00, 5'd0, 5'd0, 0, 0, 1, "sh_rst");
    step(0, 5'd1, 16'h1111, 8'h00, 8'h00, 5'd1, 5'd2, 0, 0, 1, "sh_w1111");
    step(0, 5'd0, 16'h0000, 8'h00, 8'h00, 5'd1, 5'd0, 1, 0, 1, "sh_swap1");
    step(0, 5'd1, 16'h2222, 8'h00, 8'h00, 5'd1, 5'd0, 0, 0, 1, "sh_w2222");
    step(0, 5'd0, 16'h0000, 8'h00, 8'h00, 5'd1, 5'd1, 0, 0, 1, "sh_rd2222");
    step(0, 5'd0, 16'h0000, 8'h00, 8'h00, 5'd1, 5'd0, 1, 0, 1, "sh_swap2");
    step(0, 5'd0, 16'h0000, 8'h00, 8'h00, 5'd1, 5'd0, 0, 0, 1, "sh_rd1111");
    step(0, 5'd1, 16'h3333, 8'h00, 8'h00, 5'd1, 5'd0, 1, 0, 1, "sh_w3333_swap");
    step(0, 5'd0, 16'h0000, 8'h00, 8'h00, 5'd1, 5'd0, 1, 0, 1, "sh_rd2222b");
    step(0, 5'd0, 16'h0000, 8'h00, 8'h00, 5'd1, 5'd7, 0, 0, 1, "sh_rd3333");
    step(0, 5'd0, 16'h0000, 8'hFF, 8'h5A, 5'd0, 5'd0, 0, 1, 1, "sh_fswap");
    step(0, 5'd0, 16'h0000, 8'h0F, 8'h03, 5'd0, 5'd0, 0, 0, 1, "sh_fshadow");
    step(0, 5'd0, 16'h0000, 8'h00, 8'h00, 5'd0, 5'd0, 0, 1, 1, "sh_fback");
    step(0, 5'd0, 16'h0000, 8'h00, 8'h00, 5'd0, 5'd0, 0, 0, 1, "sh_fmain");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_regfile_writer.md
Name: wb_regfile_writer

Overview:
- Write-back end of the core pipeline. Consumes the MEM-stage latch outputs (write id, flag mask, result, flags) and commits them to the architectural register file and the flag register.
- Provides two operand read ports and one flag read port to the decode/register-read stage.
- Each read port has same-cycle write-through bypass.
- Register id 0 is the null destination: writes to it are discarded and it always reads 0.

Parameters:
- DATA_W, 16, width of a register / result
- ID_W, 5, register id width (2**ID_W entries, entry 0 null)
- FLAG_W, 8, width of flag register and flag mask

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- Wr_id_in  in  ID_W  destination register id from MEM latch; 0 = no register write
- Fmask_in  in  FLAG_W  per-bit flag update enable from MEM latch
- Result_in  in  DATA_W  write data from MEM latch
- Flags_in  in  FLAG_W  new flag values from MEM latch
- rd_a_id  in  ID_W  read port A id
- rd_b_id  in  ID_W  read port B id
- rd_a_data  out  DATA_W  read port A data (combinational)
- rd_b_data  out  DATA_W  read port B data (combinational)
- flags_out  out  FLAG_W  current flag value with bypass (combinational)
- wr_count  out  16  number of committed register writes, wraps at 0xFFFF->0
- exx  in  1  bank swap request (used only with SHADOW_BANK_EN)
- ex_af  in  1  flag swap request (used only with SHADOW_BANK_EN)

Behaviour:
- Reset (RST=1 at edge):
  - all registers, the flag register and wr_count go to 0
  - shadow copies go to 0 and bank selects go to 0
  - reset wins over every simultaneous write or swap
- Register write:
  - at the edge, if Wr_id_in != 0, reg[Wr_id_in] <= Result_in and wr_count increments by 1
  - Wr_id_in == 0: no write, no count
- Flag write:
  - at every non-reset edge, F <= (F & ~Fmask_in) | (Flags_in & Fmask_in)
  - Fmask_in == 0 leaves F unchanged
  - flag updates are independent of Wr_id_in
- Repeated inputs:
  - the MEM latch holds its outputs while stalled, so identical inputs are presented on consecutive cycles
  - register and flag writes are idempotent under this; wr_count still counts every cycle with Wr_id_in != 0
- Read ports:
  - rd_x_id == 0 -> 0
  - else if rd_x_id == Wr_id_in (nonzero) -> Result_in (bypass)
  - else -> reg[rd_x_id]
  - zero-cycle latency; both ports may address the same id
- flags_out = (F & ~Fmask_in) | (Flags_in & Fmask_in), i.e. the value F will hold after the edge
- Widths:
  - no arithmetic other than wr_count, which is modulo 2**16
  - all ids are full ID_W; no out-of-range ids exist

Optional Feature:
- Macro: SHADOW_BANK_EN
- With the macro defined:
  - ids 1..6 have a second physical copy
  - bank bit rb toggles on each edge with exx=1
  - flag bank bit fb toggles on each edge with ex_af=1
  - reads, writes and bypass of ids 1..6 use the current rb; F reads and writes use the current fb
  - a write and a swap in the same cycle: the write lands in the pre-toggle bank
  - reset clears rb and fb
- Without the macro:
  - exx and ex_af are ignored
  - no shadow storage
  - ids 1..6 behave like all other ids

Test Plan:
- Reset then read: assert RST for 2 cycles with Wr_id_in=5, Result_in=0xBEEF -> after release rd_a_data(id 5)=0x0000, flags_out=0x00, wr_count=0.
- Write/read with bypass:
  - Wr_id_in=3, Result_in=0x1234, rd_a_id=3 -> rd_a_data=0x1234 in the same cycle
  - next cycle with Wr_id_in=0, rd_a_id=3 -> 0x1234
  - wr_count=1
- Null id: Wr_id_in=0, Result_in=0xFFFF for 4 cycles; rd_b_id=0 -> rd_b_data=0 throughout; wr_count unchanged.
- Flag masking: F=0x00; Flags_in=0xFF with Fmask_in=0x81 -> F=0x81; then Flags_in=0x00 with Fmask_in=0x01 -> F=0x80; Fmask_in=0x00 -> F stays 0x80.
- Stall repeat plus wrap:
  - hold Wr_id_in=7, Result_in=0x00AA for 3 cycles -> reg7=0x00AA, wr_count +3
  - preload wr_count=0xFFFF via 65535 writes, one more write -> 0x0000
- SHADOW_BANK_EN:
  - write id1=0x1111, pulse exx, write id1=0x2222 -> rd(1)=0x2222
  - pulse exx -> rd(1)=0x1111
  - exx asserted in the same cycle as a write of 0x3333 to id1 -> 0x3333 lands in the old bank
